// File: rtl/traffic_signal_monitor.sv
// Safety monitor for the two-way traffic light: checks lamp pairs for conflict, phase length,
// dark gaps and sequence, latching the first fault. TSM_FORCE_SAFE_EN adds all-red safe lamp outputs.
module traffic_signal_monitor #(
  parameter int MIN_PHASE = 3,
  parameter int MAX_PHASE = 3,
  parameter int DARK_MAX  = 0,
  parameter int RUN_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew,
  input  logic       ns,
  input  logic       clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] state,
  output logic       phase_done,
  output logic [7:0] phase_cnt
`ifdef TSM_FORCE_SAFE_EN
  ,
  output logic       safe_ew,
  output logic       safe_ns
`endif
);

  typedef enum logic [1:0] {SYNC, EW_GO, NS_GO, FAULT} state_t;

  localparam logic [2:0] C_NONE = 3'd0, C_CONFLICT = 3'd1, C_SHORT = 3'd2,
                         C_LONG = 3'd3, C_DARK = 3'd4, C_SEQ = 3'd5;
  localparam logic [RUN_W-1:0] ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] MIN_R = RUN_W'(MIN_PHASE);
  localparam logic [RUN_W-1:0] MAX_R = RUN_W'(MAX_PHASE);
  localparam logic [RUN_W-1:0] DRK_R = RUN_W'(DARK_MAX);

  state_t           cur, nxt;
  logic             p_ew, p_ns;
  logic [RUN_W-1:0] run, run_n, dark, dark_n;
  logic             first, first_n;
  logic [2:0]       code_n;
  logic             done_n;
  logic             go_ew, go_ns, both, none, own;

  assign go_ew = p_ew & ~p_ns;
  assign go_ns = ~p_ew & p_ns;
  assign both  = p_ew & p_ns;
  assign none  = ~p_ew & ~p_ns;
  assign own   = (cur == EW_GO) ? go_ew : go_ns;
  assign state = cur;

  always_comb begin
    nxt     = cur;
    run_n   = run;
    dark_n  = dark;
    first_n = first;
    code_n  = fault_code;
    done_n  = 1'b0;
    case (cur)
      SYNC: begin
        if (both) begin
          nxt = FAULT; code_n = C_CONFLICT;
        end else if (go_ew || go_ns) begin
          nxt = go_ew ? EW_GO : NS_GO; run_n = ONE; dark_n = '0;
        end
      end
      EW_GO, NS_GO: begin
        if (both) begin
          nxt = FAULT; code_n = C_CONFLICT;
        end else if (none) begin
          // run stays frozen across the dark gap so the MIN check sees the lit length
          if (dark >= DRK_R) begin
            nxt = FAULT; code_n = C_DARK;
          end else dark_n = dark + ONE;
        end else if (own) begin
          if (dark != '0) begin
            nxt = FAULT; code_n = C_SEQ;
          end else if (run >= MAX_R) begin
            nxt = FAULT; code_n = C_LONG;
          end else run_n = run + ONE;
        end else if (run < MIN_R && !first) begin
          nxt = FAULT; code_n = C_SHORT;
        end else begin
          nxt     = (cur == EW_GO) ? NS_GO : EW_GO;
          run_n   = ONE;
          dark_n  = '0;
          first_n = 1'b0;
          done_n  = 1'b1;
        end
      end
      FAULT: begin
        if (clear) begin
          nxt = SYNC; code_n = C_NONE; run_n = '0; dark_n = '0; first_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_ew       <= 1'b0;
      p_ns       <= 1'b0;
      cur        <= SYNC;
      run        <= '0;
      dark       <= '0;
      first      <= 1'b1;
      fault      <= 1'b0;
      fault_code <= C_NONE;
      phase_done <= 1'b0;
      phase_cnt  <= '0;
    end else begin
      p_ew       <= ew;
      p_ns       <= ns;
      cur        <= nxt;
      run        <= run_n;
      dark       <= dark_n;
      first      <= first_n;
      fault      <= (nxt == FAULT);
      fault_code <= code_n;
      phase_done <= done_n;
      if (done_n) phase_cnt <= phase_cnt + 8'd1;
    end
  end

`ifdef TSM_FORCE_SAFE_EN
  // blank both lamps as soon as the violating pair is seen, not one cycle later
  assign safe_ew = p_ew & (cur != FAULT) & (nxt != FAULT);
  assign safe_ns = p_ns & (cur != FAULT) & (nxt != FAULT);
`endif

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Scoreboard bench: two monitors (DARK_MAX 0 and 1) share one lamp stream; a rule-level
// model predicts each edge's outputs, and a separate monitor process compares them.
module tb_traffic_signal_monitor;
  localparam int MINP = 3, MAXP = 3;

  logic clk = 1'b0, reset, ew, ns, clear;
  logic f0, f1, d0, d1;
  logic [2:0] c0, c1;
  logic [1:0] s0, s1;
  logic [7:0] n0, n1;
`ifdef TSM_FORCE_SAFE_EN
  logic se0, sn0, se1, sn1;
`endif

  always #5 clk = ~clk;

  traffic_signal_monitor #(.DARK_MAX(0)) u_dut0 (
    .clk(clk), .reset(reset), .ew(ew), .ns(ns), .clear(clear),
    .fault(f0), .fault_code(c0), .state(s0), .phase_done(d0), .phase_cnt(n0)
`ifdef TSM_FORCE_SAFE_EN
    , .safe_ew(se0), .safe_ns(sn0)
`endif
  );

  traffic_signal_monitor #(.DARK_MAX(1)) u_dut1 (
    .clk(clk), .reset(reset), .ew(ew), .ns(ns), .clear(clear),
    .fault(f1), .fault_code(c1), .state(s1), .phase_done(d1), .phase_cnt(n1)
`ifdef TSM_FORCE_SAFE_EN
    , .safe_ew(se1), .safe_ns(sn1)
`endif
  );

  typedef struct {
    bit pe, pn;
    int st, run, dark;
    bit first, flt;
    int code;
    bit pd;
    int cnt;
    int dmax;
  } mdl_t;
  typedef struct {mdl_t a; mdl_t b;} exp_t;

  exp_t q[$];
  exp_t mon_x;
  mdl_t m0, m1;
  int   checks = 0, failures = 0;

  function automatic mdl_t mreset(int dmax);
    mdl_t r;
    r.pe = 0; r.pn = 0; r.st = 0; r.run = 0; r.dark = 0; r.first = 1;
    r.flt = 0; r.code = 0; r.pd = 0; r.cnt = 0; r.dmax = dmax;
    return r;
  endfunction

  // One clock edge: judge the previously sampled lamp pair, then sample the new one.
  function automatic mdl_t mstep(mdl_t m, bit e, bit n, bit c);
    mdl_t r = m;
    int dir = (m.pe && !m.pn) ? 1 : ((!m.pe && m.pn) ? 2 : 0);
    int viol = 0;
    r.pd = 0; r.pe = e; r.pn = n;
    if (m.st == 3) begin
      if (c) begin
        r.st = 0; r.flt = 0; r.code = 0; r.run = 0; r.dark = 0; r.first = 1;
      end
      return r;
    end
    if (m.pe && m.pn) viol = 1;
    else if (m.st == 0) begin
      if (dir != 0) begin r.st = dir; r.run = 1; r.dark = 0; end
    end else if (dir == 0) begin
      if (m.dark + 1 > m.dmax) viol = 4; else r.dark = m.dark + 1;
    end else if (dir == m.st) begin
      if (m.dark > 0) viol = 5;
      else if (m.run == MAXP) viol = 3;
      else r.run = m.run + 1;
    end else if (m.run < MINP && !m.first) viol = 2;
    else begin
      r.st = dir; r.run = 1; r.dark = 0; r.pd = 1; r.cnt = (m.cnt + 1) % 256; r.first = 0;
    end
    if (viol != 0) begin r.st = 3; r.flt = 1; r.code = viol; end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic f, input logic [2:0] c,
                     input logic [1:0] s, input logic d, input logic [7:0] n);
    chk({tag, "_state"}, 32'(s), m.st);
    chk({tag, "_fault"}, 32'(f), int'(m.flt));
    chk({tag, "_code"},  32'(c), m.code);
    chk({tag, "_done"},  32'(d), int'(m.pd));
    chk({tag, "_cnt"},   32'(n), m.cnt);
  endtask

`ifdef TSM_FORCE_SAFE_EN
  task automatic cmp_safe(input string tag, input mdl_t m, input logic se, input logic sn);
    bit ok = (m.st != 3) && (mstep(m, 0, 0, 0).st != 3);
    chk({tag, "_safe_ew"}, 32'(se), int'(m.pe && ok));
    chk({tag, "_safe_ns"}, 32'(sn), int'(m.pn && ok));
  endtask
`endif

  task automatic zero_chk(input string tag);
    chk({tag, "_s0"}, 32'(s0), 0); chk({tag, "_f0"}, 32'(f0), 0); chk({tag, "_c0"}, 32'(c0), 0);
    chk({tag, "_d0"}, 32'(d0), 0); chk({tag, "_n0"}, 32'(n0), 0);
    chk({tag, "_s1"}, 32'(s1), 0); chk({tag, "_f1"}, 32'(f1), 0); chk({tag, "_c1"}, 32'(c1), 0);
    chk({tag, "_d1"}, 32'(d1), 0); chk({tag, "_n1"}, 32'(n1), 0);
  endtask

  // Drive one cycle of lamps; the expected result of the next edge goes to the scoreboard.
  task automatic step(input bit e, input bit n, input bit c);
    exp_t x;
    ew = e; ns = n; clear = c;
    m0 = mstep(m0, e, n, c);
    m1 = mstep(m1, e, n, c);
    x.a = m0; x.b = m1;
    q.push_back(x);
    @(posedge clk); #2;
  endtask

  task automatic phase(input bit e, input bit n, input int len);
    for (int i = 0; i < len; i++) step(e, n, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    zero_chk(tag);
    m0 = mreset(0);
    m1 = mreset(1);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        mon_x = q.pop_front();
        cmp("dk0", mon_x.a, f0, c0, s0, d0, n0);
        cmp("dk1", mon_x.b, f1, c1, s1, d1, n1);
`ifdef TSM_FORCE_SAFE_EN
        cmp_safe("dk0", mon_x.a, se0, sn0);
        cmp_safe("dk1", mon_x.b, se1, sn1);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dir, len, gap;
    ew = 0; ns = 0; clear = 0; reset = 1'b1;
    m0 = mreset(0); m1 = mreset(1);
    @(posedge clk); #2;
    do_reset("rst");

    // ten regular phases: nine hand-overs
    for (int i = 0; i < 10; i++) phase(i % 2 == 0, i % 2 == 1, 3);
    chk("cnt_after_10", 32'(n0), 9);
    chk("fault_after_10", 32'(f0), 0);

    // conflict during NS_GO, then later changes must not move the code
    step(1, 1, 0); step(0, 1, 0); step(0, 1, 0); step(1, 0, 0);
    chk("conflict_code", 32'(c0), 1);
    step(0, 0, 1);

    // first phase short is exempt; short non-first phase faults
    phase(1, 0, 2); phase(0, 1, 3); phase(1, 0, 2); phase(0, 1, 2);
    step(0, 0, 1);
    // long phase after a legal hand-over
    phase(1, 0, 3); phase(0, 1, 3); phase(1, 0, 4); step(0, 0, 0);
    step(0, 0, 1);
    // dark gap of one: legal only with DARK_MAX=1
    phase(1, 0, 3); step(0, 0, 0); phase(0, 1, 3);
    step(0, 0, 1);
    // two dark cycles, then same direction returning after dark
    phase(1, 0, 3); phase(0, 0, 2); step(0, 0, 0);
    step(0, 0, 1);
    phase(1, 0, 3); step(0, 0, 0); phase(1, 0, 2);
    step(0, 0, 1); step(0, 0, 1);

    // randomized controller-like traffic with faults, gaps and stray clears
    dir = 1;
    for (int p = 0; p < 150; p++) begin
      if ((m0.st == 3 || m1.st == 3) && $urandom_range(0, 2) == 0) step(0, 0, 1);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 3;
      if ($urandom_range(0, 19) == 0) step(1, 1, 0);
      for (int j = 0; j < len; j++) step(dir == 1, dir == 2, $urandom_range(0, 15) == 0);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int j = 0; j < gap; j++) step(0, 0, 0);
      if ($urandom_range(0, 7) != 0) dir = 3 - dir;
    end

    // asynchronous reset in the middle of NS_GO
    step(0, 0, 1); step(0, 0, 1);
    phase(1, 0, 3); phase(0, 1, 2);
    do_reset("async_rst");
    phase(1, 0, 2);

    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
